project_seq_detector: RTL and testbench
=======================================

Name: project_seq_detector

Overview:
- Serial bit-stream sequence detector: samples one input bit `x` per rising clock edge and compares the recent history against a programmable pattern.
- Asserts a registered (Moore-style) one-cycle flag `z` after the final bit of each match.
- Leaf block in the CSC 137 project datapath; default configuration detects overlapping "1001".

Parameters:
- PATTERN_LEN, 4, number of bits in the target pattern; legal 2..16.
- PATTERN, 4'b1001, target pattern, PATTERN_LEN bits wide; MSB is the first bit received, LSB the last.
- OVERLAP, 1, 1 = trailing bits of a match may start the next match; 0 = history restarts empty after each match.

Ports:
- clock, input, 1, single system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset. Port is named `reset`; asserted when 0.
- x, input, 1, serial data bit, sampled on each rising edge of clock.
- z, output, 1, registered detect flag; 1 for exactly one cycle per detected match.

Behaviour:
- Reset (reset == 0, asynchronous):
  - z = 0 immediately.
  - Match-progress state = 0 bits matched; any partial match is discarded.
  - While reset is held, z stays 0 and x is ignored.
- Release: first sample taken on the first rising edge with reset == 1.
- State:
  - Implemented as a prefix-match FSM (states S0..S{PATTERN_LEN-1} = number of pattern bits currently matched) or an equivalent shift register plus valid-bit counter.
  - The shift-register form must not detect until PATTERN_LEN bits have been received since reset or since the last non-overlap match.
- Transition on each rising edge, with k = bits matched and b = x:
  - If b equals PATTERN bit (PATTERN_LEN-1-k): k+1.
  - Otherwise: longest proper prefix of PATTERN that is a suffix of the received history (KMP fallback).
  - Fallback must be correct for any PATTERN, including self-overlapping patterns such as 1001 and 1111.
- Match: when k+1 == PATTERN_LEN on an edge, z is registered to 1 at that edge and held through the next edge.
  - Latency: z rises at the same edge that samples the last pattern bit, visible for that clock cycle.
  - Next state after a match:
    - OVERLAP=1: the KMP fallback of the full pattern (for 1001, 1 bit matched).
    - OVERLAP=0: S0.
- z = 0 on every edge without a match; back-to-back matches keep z = 1 on consecutive cycles (possible only when OVERLAP=1, e.g. pattern 11 fed 111).
- Reset mid-match: pattern progress is lost; bits received before reset never contribute to a later match.
- No handshake, no back-pressure; x is valid every cycle.
- Outputs come only from flops; no combinational path from x to z.

Test Plan:
- Reset: hold reset=0 for 10 time units with x toggling -> z = 0 throughout; no detection at release.
- Default stream: x = 0,0,1,0,0,1,1,0,0,1,0,0,1 on 13 consecutive edges after release -> z = 1 after edges 6, 10 and 13 (the overlap at bit 10 counts); z = 0 on all other cycles.
- OVERLAP=0, same stream -> z = 1 after edges 6 and 10 only; the third 1001 is rejected because bit 10 was consumed.
- Mid-match reset: feed 1,0,0, pulse reset=0 asynchronously between edges, then feed 1 -> z stays 0; then 1,0,0,1 -> z = 1 after the final 1.
- Self-overlap: PATTERN_LEN=2, PATTERN=2'b11, OVERLAP=1, x = 1,1,1,1 -> z = 1 after edges 2, 3 and 4 (consecutive cycles); with OVERLAP=0 -> z = 1 after edges 2 and 4 only.
- Near-miss: default pattern, x = 1,0,1,0,0,1 -> one detect after the last edge (fallback from S2 on a 1 goes to S1).

Source files
------------

// File: rtl/project_seq_detector.sv
// Serial sequence detector: prefix-match FSM with KMP fallback.
// Registered one-cycle detect flag z after the last bit of each match.
module project_seq_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1001,
  parameter bit                     OVERLAP     = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic x,
  output logic z
);

  localparam int SW = $clog2(PATTERN_LEN);

  typedef logic [SW-1:0] state_t;

  // i-th pattern bit in arrival order (0 = first bit received)
  function automatic logic pbit(input int i);
    logic [PATTERN_LEN-1:0] t;
    t = PATTERN >> (PATTERN_LEN - 1 - i);
    return t[0];
  endfunction

  // Longest proper prefix that is a suffix of (prefix[0..k-1], b)
  function automatic int kmp_next(input int k, input logic b);
    int   res;
    int   pos;
    logic ok;
    logic c;
    res = 0;
    for (int l = 1; l < PATTERN_LEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          pos = k + 1 - l + j;
          c = (pos < k) ? pbit(pos) : b;
          if (c != pbit(j)) ok = 1'b0;
        end
        if (ok) res = l;
      end
    end
    return res;
  endfunction

  localparam state_t LAST_S = state_t'(PATTERN_LEN - 1);
  localparam logic   LAST_B = pbit(PATTERN_LEN - 1);

  state_t nxt0 [PATTERN_LEN];
  state_t nxt1 [PATTERN_LEN];

  for (genvar g = 0; g < PATTERN_LEN; g++) begin : g_tab
    localparam state_t N0 = state_t'(kmp_next(g, 1'b0));
    localparam state_t N1 = state_t'(kmp_next(g, 1'b1));
    assign nxt0[g] = N0;
    assign nxt1[g] = N1;
  end

  state_t state_q;
  state_t state_d;
  logic   hit;
  logic   z_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= hit;
    end
  end

  always_comb begin
    hit     = 1'b0;
    state_d = x ? nxt1[state_q] : nxt0[state_q];
    if (state_q == LAST_S && x == LAST_B) begin
      hit = 1'b1;
      if (!OVERLAP) state_d = '0;
    end
  end

  always_comb begin
    z = z_q;
  end

endmodule

// File: tb/tb_project_seq_detector.sv
// Bench for project_seq_detector: directed streams plus random
// stimulus against a bit-history reference model, five configs.
module tb_project_seq_detector;

  localparam int NM = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          x;
  logic [NM-1:0] zv;

  always #5 clock = ~clock;

  project_seq_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b1)
  ) u0 (.clock(clock), .reset(reset), .x(x), .z(zv[0]));

  project_seq_detector #(
    .PATTERN_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b0)
  ) u1 (.clock(clock), .reset(reset), .x(x), .z(zv[1]));

  project_seq_detector #(
    .PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)
  ) u2 (.clock(clock), .reset(reset), .x(x), .z(zv[2]));

  project_seq_detector #(
    .PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b0)
  ) u3 (.clock(clock), .reset(reset), .x(x), .z(zv[3]));

  project_seq_detector #(
    .PATTERN_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1)
  ) u4 (.clock(clock), .reset(reset), .x(x), .z(zv[4]));

  int          lens [NM] = '{4, 4, 2, 2, 5};
  logic [15:0] pats [NM] = '{16'h9, 16'h9, 16'h3, 16'h3, 16'h1b};
  bit          ovl  [NM] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  bit            hq [NM][$];
  logic [NM-1:0] zexp;
  logic [31:0]   rec [NM];
  int            n_chk  = 0;
  int            n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Match = the last LEN bits received since reset (or since the
  // last non-overlap match) spell the pattern.
  function automatic bit model_push(input int i, input bit b);
    int  sz;
    bit  pb;
    hq[i].push_back(b);
    if (hq[i].size() > 32) void'(hq[i].pop_front());
    sz = hq[i].size();
    if (sz < lens[i]) return 1'b0;
    for (int j = 0; j < lens[i]; j++) begin
      pb = 1'(pats[i] >> (lens[i] - 1 - j));
      if (hq[i][sz - lens[i] + j] != pb) return 1'b0;
    end
    if (!ovl[i]) hq[i].delete();
    return 1'b1;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < NM; i++) hq[i].delete();
  endtask

  task automatic check_all(input string what);
    for (int i = 0; i < NM; i++)
      check($sformatf("%s z%0d", what, i), 32'(zv[i]), 32'(zexp[i]));
  endtask

  task automatic step(input bit b, output logic [NM-1:0] zs);
    @(negedge clock);
    x = b;
    @(posedge clock);
    for (int i = 0; i < NM; i++) zexp[i] = model_push(i, b);
    #1;
    check_all("step");
    zs = zv;
  endtask

  // Reset pulse placed between a rising and a falling edge
  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    zexp = '0;
    clear_models();
    check_all("rst");
    #1 reset = 1'b1;
  endtask

  task automatic play(input logic [31:0] v, input int n);
    logic [NM-1:0] zs;
    for (int i = 0; i < NM; i++) rec[i] = '0;
    for (int k = 0; k < n; k++) begin
      step(v[n - 1 - k], zs);
      for (int i = 0; i < NM; i++) rec[i] = {rec[i][30:0], zs[i]};
    end
  endtask

  initial begin
    logic [NM-1:0] zs;
    reset = 1'b0;
    x     = 1'b0;
    zexp  = '0;
    for (int i = 0; i < 10; i++) begin
      #1 x = ~x;
      check_all("hold");
    end
    @(posedge clock);
    #1 reset = 1'b1;

    play(32'b0010011001001, 13);
    check("dflt_ovl", rec[0], 32'b0000010001001);
    check("dflt_novl", rec[1], 32'b0000010001000);

    pulse_reset();
    play(32'b1111, 4);
    check("p11_ovl", rec[2], 32'b0111);
    check("p11_novl", rec[3], 32'b0101);

    pulse_reset();
    play(32'b101001, 6);
    check("near_miss", rec[0], 32'b000001);

    pulse_reset();
    play(32'b11011011, 8);
    check("p11011", rec[4], 32'b00001001);

    pulse_reset();
    play(32'b100, 3);
    pulse_reset();
    play(32'b11001, 5);
    check("mid_rst", rec[0], 32'b00001);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else step(1'($urandom_range(0, 1)), zs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
